// File: rtl/casio_disp_pkg.sv
// Shared constants and helpers for the casio 7-segment display driver.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package casio_disp_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg_encode(input logic [3:0] val);
        case (val)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_2digit.sv
// Combinational 6-bit binary to two BCD digits, valid for 0..63.
module bin2bcd_2digit (
    input  logic [5:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [5:0] tens_full;
    logic [5:0] ones_full;

    assign tens_full = bin / 6'd10;
    assign ones_full = bin % 6'd10;
    assign tens      = tens_full[3:0];
    assign ones      = ones_full[3:0];

endmodule

// File: rtl/casio_display_driver.sv
// 4-digit multiplexed common-anode display of HH:MM with per-frame shadowing,
// colon blink, edit-digit blink and alarm flash. All outputs registered.
module casio_display_driver
    import casio_disp_pkg::*;
#(
    parameter int SCAN_DIV  = 4,
    parameter int BLINK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] hours,
    input  logic [5:0] minutes,
    input  logic       ring,
    input  logic       edit_active,
    input  logic [1:0] edit_digit,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_DIV);

    logic [SW-1:0] scan_cnt_reg;
    digit_idx_t    digit_reg;
    logic [BW-1:0] blink_cnt_reg;
    logic          blink_phase_reg;
    logic [4:0]    hours_shadow_reg;
    logic [5:0]    minutes_shadow_reg;
    logic          first_reg;
    logic [3:0]    an_reg;
    logic [6:0]    seg_reg;
    logic          dp_reg;

    logic          scan_tc;
    logic          blink_tc;
    logic          reload;
    logic [4:0]    hours_disp;
    logic [5:0]    minutes_disp;
    logic [3:0]    h_tens, h_ones, m_tens, m_ones;
    logic [3:0]    digit_val;
    logic          digit_bad;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;

    assign scan_tc  = (scan_cnt_reg == SW'(SCAN_DIV - 1));
    assign blink_tc = (blink_cnt_reg == BW'(BLINK_DIV - 1));
    assign reload   = first_reg | (scan_tc & (digit_reg == 2'd3));

    // The first post-reset edge displays digit 0 while loading, so it must see the live inputs.
    assign hours_disp   = first_reg ? hours   : hours_shadow_reg;
    assign minutes_disp = first_reg ? minutes : minutes_shadow_reg;

    bin2bcd_2digit u_hours_bcd (
        .bin  ({1'b0, hours_disp}),
        .tens (h_tens),
        .ones (h_ones)
    );

    bin2bcd_2digit u_minutes_bcd (
        .bin  (minutes_disp),
        .tens (m_tens),
        .ones (m_ones)
    );

    for (genvar gi = 0; gi < 4; gi++) begin : g_an
        assign an_next[3-gi] = (digit_reg != digit_idx_t'(gi));
    end

    always_comb begin
        digit_val = 4'd0;
        digit_bad = 1'b0;
        case (digit_reg)
            2'd0: begin digit_val = h_tens; digit_bad = (hours_disp > 5'd23);   end
            2'd1: begin digit_val = h_ones; digit_bad = (hours_disp > 5'd23);   end
            2'd2: begin digit_val = m_tens; digit_bad = (minutes_disp > 6'd59); end
            default: begin digit_val = m_ones; digit_bad = (minutes_disp > 6'd59); end
        endcase

        seg_next = digit_bad ? SEG_DASH : seg_encode(digit_val);
        if (ring && !blink_phase_reg) begin
            seg_next = SEG_BLANK;
        end else if (edit_active && (digit_reg == edit_digit) && !blink_phase_reg) begin
            seg_next = SEG_BLANK;
        end

        dp_next = !((digit_reg == 2'd1) && blink_phase_reg);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_reg       <= '0;
            digit_reg          <= '0;
            blink_cnt_reg      <= '0;
            blink_phase_reg    <= 1'b0;
            hours_shadow_reg   <= '0;
            minutes_shadow_reg <= '0;
            first_reg          <= 1'b1;
            an_reg             <= 4'b1111;
            seg_reg            <= SEG_BLANK;
            dp_reg             <= 1'b1;
        end else begin
            first_reg <= 1'b0;
            if (scan_tc) begin
                scan_cnt_reg <= '0;
                digit_reg    <= digit_reg + 2'd1;
            end else begin
                scan_cnt_reg <= scan_cnt_reg + SW'(1);
            end
            if (blink_tc) begin
                blink_cnt_reg   <= '0;
                blink_phase_reg <= ~blink_phase_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + BW'(1);
            end
            if (reload) begin
                hours_shadow_reg   <= hours;
                minutes_shadow_reg <= minutes;
            end
            an_reg  <= an_next;
            seg_reg <= seg_next;
            dp_reg  <= dp_next;
        end
    end

    assign an  = an_reg;
    assign seg = seg_reg;
    assign dp  = dp_reg;

endmodule

// File: tb/tb_casio_display_driver.sv
// Self-checking bench: directed scenarios plus random stimulus against a
// cycle-count based model of the HH:MM scan display.
module tb_casio_display_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic       ring;
    logic       edit_active;
    logic [1:0] edit_digit;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int errors = 0;
    int checks = 0;

    // model state: edges since reset release and the value pair latched for the current frame
    int k = 0;
    int sh_h = 0;
    int sh_m = 0;

    logic [6:0] enc [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    always #5 clk = ~clk;

    casio_display_driver #(.SCAN_DIV(4), .BLINK_DIV(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .hours       (hours),
        .minutes     (minutes),
        .ring        (ring),
        .edit_active (edit_active),
        .edit_digit  (edit_digit),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    task automatic step(input string tag);
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        int d, ph, v, val;
        bit bad;
        @(posedge clk);
        if (rst) begin
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
            k = 0;
        end else begin
            if (k == 0) begin sh_h = int'(hours); sh_m = int'(minutes); end
            d  = (k / 4) % 4;
            ph = (k / 16) % 2;
            v   = (d < 2) ? sh_h : sh_m;
            bad = (d < 2) ? (sh_h > 23) : (sh_m > 59);
            val = (d % 2 == 0) ? v / 10 : v % 10;
            exp_seg = bad ? 7'h3F : enc[val];
            if (ring && ph == 0) exp_seg = 7'h7F;
            else if (edit_active && d == int'(edit_digit) && ph == 0) exp_seg = 7'h7F;
            exp_an = ~(4'b1000 >> d);
            exp_dp = !(d == 1 && ph == 1);
            if (k % 16 == 15) begin sh_h = int'(hours); sh_m = int'(minutes); end
            k++;
        end
        #1;
        checks++;
        assert (an === exp_an) else begin
            errors++;
            $error("FAIL %s an k=%0d observed=%h expected=%h", tag, k, an, exp_an);
        end
        checks++;
        assert (seg === exp_seg) else begin
            errors++;
            $error("FAIL %s seg k=%0d observed=%h expected=%h", tag, k, seg, exp_seg);
        end
        checks++;
        assert (dp === exp_dp) else begin
            errors++;
            $error("FAIL %s dp k=%0d observed=%b expected=%b", tag, k, dp, exp_dp);
        end
        $display("step %s k=%0d h=%0d m=%0d ring=%b edit=%b/%0d -> an=%h seg=%h dp=%b",
                 tag, k, hours, minutes, ring, edit_active, edit_digit, an, seg, dp);
    endtask

    initial begin
        rst = 1'b1; hours = 5'd12; minutes = 6'd34;
        ring = 1'b0; edit_active = 1'b0; edit_digit = 2'd0;
        #2;
        for (int i = 0; i < 3; i++) step("reset");

        rst = 1'b0;
        for (int i = 0; i < 64; i++) step("static_1234");

        // minutes change while digit 2 is on: current frame must keep 34
        while (k % 16 != 9) step("pre_tear");
        minutes = 6'd35;
        for (int i = 0; i < 32; i++) step("anti_tear");

        hours = 5'd25; minutes = 6'd7;
        for (int i = 0; i < 32; i++) step("range_dash");
        hours = 5'd0; minutes = 6'd0;
        for (int i = 0; i < 32; i++) step("zero");

        hours = 5'd12; minutes = 6'd34;
        edit_active = 1'b1; edit_digit = 2'd2;
        for (int i = 0; i < 48; i++) step("edit_d2");
        ring = 1'b1;
        for (int i = 0; i < 48; i++) step("ring_edit");
        ring = 1'b0;
        for (int i = 0; i < 32; i++) step("ring_off");

        // mid-scan reset
        edit_active = 1'b0;
        for (int i = 0; i < 6; i++) step("pre_rst");
        rst = 1'b1;
        step("mid_rst");
        rst = 1'b0;
        for (int i = 0; i < 20; i++) step("post_rst");

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 15) == 0) hours   = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) minutes = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 20) == 0) ring = ~ring;
            if ($urandom_range(0, 10) == 0) edit_active = ~edit_active;
            if ($urandom_range(0, 10) == 0) edit_digit = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 120) == 0);
            step("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
